// File: rtl/fphub_mult.sv
// fphub_mult: two-stage pipelined multiplier for HUB floating-point operands.
//
// Operand format is {sign, exp[E-1:0], frac[M-1:0]} with an implicit leading 1
// and an implicit trailing 1 (ILSB). Truncating the product is round-to-nearest
// under HUB, so no rounding hardware is needed. exp == 0 encodes zero and
// exp == all-ones encodes infinity; there are no subnormals and no NaN.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   X/Y are sampled this cycle
//   X, Y       operands
//   out_valid  Z holds a new result (in_valid delayed by two cycles)
//   Z          product; holds its last value when out_valid is low
module fphub_mult #(
    parameter int unsigned M = 23,
    parameter int unsigned E = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    input  logic [E+M:0]   X,
    input  logic [E+M:0]   Y,
    output logic           out_valid,
    output logic [E+M:0]   Z
);

    localparam int unsigned W  = E + M + 1;
    localparam int unsigned PW = 2 * M + 4;
    localparam int unsigned EW = E + 2;

    localparam logic [EW-1:0] Bias   = EW'(2 ** (E - 1));
    localparam logic [EW-1:0] ExpMax = EW'((2 ** E) - 1);

    // Operand field decode
    logic [E-1:0]  x_exp, y_exp;
    logic [M+1:0]  x_man, y_man;

    // Stage 1 next-state and registers
    logic           s1_zero_d, s1_inf_d;
    logic [EW-1:0]  s1_exp_d;
    logic [PW-1:0]  s1_prod_d;

    logic           s1_valid_q;
    logic           s1_sign_q;
    logic           s1_zero_q;
    logic           s1_inf_q;
    logic [EW-1:0]  s1_exp_q;
    logic [PW-1:0]  s1_prod_q;

    // Stage 2 combinational result
    logic           norm;
    logic [EW-1:0]  ez;
    logic [M-1:0]   frac_n;
    logic [W-1:0]   z_d;

    // ---------------------------------------------------------------- stage 1
    always_comb begin
        x_exp     = X[W-2 -: E];
        y_exp     = Y[W-2 -: E];
        x_man     = {1'b1, X[M-1:0], 1'b1};
        y_man     = {1'b1, Y[M-1:0], 1'b1};
        s1_zero_d = (x_exp == '0) || (y_exp == '0);
        s1_inf_d  = (&x_exp) || (&y_exp);
        // Biased sum carried with two guard bits so over/underflow stays visible.
        s1_exp_d  = EW'(x_exp) + EW'(y_exp) - Bias;
        s1_prod_d = PW'(x_man) * PW'(y_man);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_inf_q   <= 1'b0;
            s1_exp_q   <= '0;
            s1_prod_q  <= '0;
        end else begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sign_q <= X[W-1] ^ Y[W-1];
                s1_zero_q <= s1_zero_d;
                s1_inf_q  <= s1_inf_d;
                s1_exp_q  <= s1_exp_d;
                s1_prod_q <= s1_prod_d;
            end
        end
    end

    // ---------------------------------------------------------------- stage 2
    always_comb begin
        // Product lies in [1,4); the top bit marks the [2,4) half.
        norm   = s1_prod_q[PW-1];
        ez     = s1_exp_q + EW'(norm);
        frac_n = norm ? s1_prod_q[PW-2 -: M] : s1_prod_q[PW-3 -: M];

        z_d = {s1_sign_q, ez[E-1:0], frac_n};
        if (s1_zero_q) begin
            // Zero wins over infinity, so 0 x inf is a signed zero.
            z_d = {s1_sign_q, {(W-1){1'b0}}};
        end else if (s1_inf_q) begin
            z_d = {s1_sign_q, {(W-1){1'b1}}};
        end else if (ez[EW-1] || (ez == '0)) begin
            z_d = {s1_sign_q, {(W-1){1'b0}}};
        end else if (ez >= ExpMax) begin
            z_d = {s1_sign_q, {(W-1){1'b1}}};
        end
    end

    // Bits below the kept fraction are discarded by truncation.
    logic unused_prod;
    assign unused_prod = ^s1_prod_q[PW-3-M:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            Z         <= '0;
        end else begin
            out_valid <= s1_valid_q;
            if (s1_valid_q) begin
                Z <= z_d;
            end
        end
    end

endmodule

// File: tb/tb_fphub_mult.sv
// Directed and random checks for fphub_mult (M=23, E=8).
module tb_fphub_mult;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] X, Y;
    logic        out_valid;
    logic [31:0] Z;

    int checks   = 0;
    int failures = 0;

    fphub_mult #(.M(23), .E(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .X         (X),
        .Y         (Y),
        .out_valid (out_valid),
        .Z         (Z)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Exact HUB product, truncated below the leading one.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic              s;
        int                ea, eb, ez;
        longint unsigned   ma, mb, p;
        logic [22:0]       fr;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 0 || eb == 0) return {s, 31'h0};
        if (ea == 255 || eb == 255) return {s, 31'h7FFFFFFF};
        ma = (longint'(1) << 24) | (longint'(a[22:0]) << 1) | 1;
        mb = (longint'(1) << 24) | (longint'(b[22:0]) << 1) | 1;
        p  = ma * mb;
        ez = ea + eb - 128;
        if (p >= (longint'(1) << 49)) begin
            ez++;
            fr = 23'(p >> 26);
        end else begin
            fr = 23'(p >> 25);
        end
        if (ez >= 255) return {s, 31'h7FFFFFFF};
        if (ez <= 0) return {s, 31'h0};
        return {s, 8'(ez), fr};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0] e;
        if ($urandom_range(0, 1) == 1) e = 8'($urandom_range(1, 254));
        else e = 8'($urandom_range(64, 191));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    // Single transaction: checks latency, result and hold behaviour.
    task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
        @(negedge clk);
        in_valid = 1'b1;
        X = a;
        Y = b;
        @(negedge clk);
        in_valid = 1'b0;
        X = 32'h0;
        Y = 32'h0;
        check_eq({tag, "_early"}, {31'h0, out_valid}, 32'h0);
        @(negedge clk);
        check_eq({tag, "_vld"}, {31'h0, out_valid}, 32'h1);
        check_eq(tag, Z, exp);
        @(negedge clk);
        check_eq({tag, "_hold"}, Z, exp);
    endtask

    logic [31:0] sx [4] = '{32'h40400000, 32'h40000000, 32'h40200000, 32'hC0400000};
    logic [31:0] sy [4] = '{32'h40400000, 32'h40000000, 32'h41000000, 32'h40400000};
    logic [31:0] sz [4] = '{32'h40900000, 32'h40000001, 32'h41200001, 32'hC0900000};
    logic [31:0] expq [$];

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        X = 32'h0;
        Y = 32'h0;
        repeat (3) @(negedge clk);
        check_eq("rst_z", Z, 32'h0);
        check_eq("rst_vld", {31'h0, out_valid}, 32'h0);
        rst_n = 1'b1;

        run_vec("m1p5x1p5", 32'h40400000, 32'h40400000, 32'h40900000);
        run_vec("m1x1_ilsb", 32'h40000000, 32'h40000000, 32'h40000001);
        run_vec("m1p25x4", 32'h40200000, 32'h41000000, 32'h41200001);
        run_vec("neg1p5x1p5", 32'hC0400000, 32'h40400000, 32'hC0900000);
        run_vec("inf_x_pos", 32'h7FFFFFFF, 32'h40C00000, 32'h7FFFFFFF);
        run_vec("ninf_x_neg", 32'hFFFFFFFF, 32'hC0A00000, 32'h7FFFFFFF);
        run_vec("zero_x_pos", 32'h00000000, 32'h40A00000, 32'h00000000);
        run_vec("ninf_x_zero", 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run_vec("ovf", 32'h7F000000, 32'h7F000000, 32'h7FFFFFFF);
        run_vec("unf", 32'h00800000, 32'h00800000, 32'h00000000);
        run_vec("ez254", 32'h5F800000, 32'h5F800000, 32'h7F000001);
        run_vec("ez255", 32'h5F800000, 32'h60000000, 32'h7FFFFFFF);
        run_vec("norm_ovf", 32'h5FC00000, 32'h5FC00000, 32'h7FFFFFFF);
        run_vec("ez0", 32'h20000000, 32'h20000000, 32'h00000000);
        run_vec("ez1", 32'h20000000, 32'h20800000, 32'h00800001);
        run_vec("norm_unf", 32'h20400000, 32'h20400000, 32'h00900000);

        // Back-to-back stream: results must come out on consecutive cycles.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                check_eq($sformatf("strm_vld%0d", k - 2), {31'h0, out_valid}, 32'h1);
                check_eq($sformatf("strm_z%0d", k - 2), Z, sz[k-2]);
            end
            if (k < 4) begin
                in_valid = 1'b1;
                X = sx[k];
                Y = sy[k];
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check_eq("strm_end", {31'h0, out_valid}, 32'h0);

        // Reset in the middle of a stream.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            X = sx[k];
            Y = sy[k];
        end
        check_eq("mid_pre_vld", {31'h0, out_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check_eq("mid_rst_z", Z, 32'h0);
        check_eq("mid_rst_vld", {31'h0, out_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq($sformatf("post_rst_vld%0d", k), {31'h0, out_valid}, 32'h0);
        end
        run_vec("post_rst", 32'h40400000, 32'h40400000, 32'h40900000);

        // Random normal operands against the reference model.
        for (int k = 0; k < 10002; k++) begin
            logic [31:0] a, b, e;
            @(negedge clk);
            if (k >= 2) begin
                e = expq.pop_front();
                check_eq("rnd_vld", {31'h0, out_valid}, 32'h1);
                check_eq("rnd_z", Z, e);
            end
            if (k < 10000) begin
                a = rand_op();
                b = rand_op();
                expq.push_back(ref_mul(a, b));
                in_valid = 1'b1;
                X = a;
                Y = b;
            end else begin
                in_valid = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fphub_mult.md
Name: fphub_mult

Overview:
- Pipelined floating-point multiplier for HUB (Half-Unit-Biased) operands: sign | E-bit exponent | M-bit fraction, with an implicit leading 1 and an implicit trailing LSB of 1 (ILSB).
- Round-to-nearest is obtained by truncation, so there is no rounding logic.
- Used as the multiply unit of the HUB FP datapath.
- Two-stage pipeline with a valid strobe and no backpressure.

Parameters:
- M, 23, fraction width (stored bits, excluding implicit leading 1 and ILSB).
- E, 8, exponent width. Bias = 2^(E-1) (128 for E=8).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  X/Y are sampled this cycle.
- X  in  E+M+1  operand A, {sign, exp, frac}.
- Y  in  E+M+1  operand B.
- out_valid  out  1  Z holds a new result.
- Z  out  E+M+1  product.

Behaviour:
Encoding and operand classes
- Value = (-1)^s · 2^(exp−bias) · 1.frac1. The trailing 1 has weight 2^-(M+1).
- exp == 0 → zero; the fraction is ignored. No subnormals.
- exp == all-ones → infinity; the fraction is ignored.
- Canonical infinity output: exp all-ones, frac all-ones.
- Canonical zero output: exp 0, frac 0.
- Otherwise the operand is normal.

Sign
- Zs = Xs XOR Ys in every case, including zero and infinity results.

Special cases, in priority order
1. Either operand zero → signed zero. This includes 0 × inf; no NaN is produced.
2. Else either operand infinity → signed canonical infinity.

Normal path
- Mx = {1, Xfrac, 1}, My = {1, Yfrac, 1}, each M+2 bits.
- P = Mx·My, 2M+4 bits, value in [1,4).
- If P ≥ 2 (top bit set): normalise right by 1, exponent +1.
- Result fraction = the M bits immediately below the leading 1, truncated. The ILSB of the result implies the rounding.
- Exponent, computed signed with ≥ E+2 bits: Ez = Xexp + Yexp − bias + norm.
- Ez ≥ 2^E − 1 → signed infinity (overflow).
- Ez ≤ 0 → signed zero (underflow).
- Otherwise Z = {Zs, Ez[E-1:0], frac}.

Pipeline
- Stage 1 (on in_valid): register the sign, operand classes, exponent sum and full mantissa product.
- Stage 2: normalise, apply exponent checks and special cases, register Z.
- Latency is exactly 2 cycles; a new operand pair is accepted every cycle.
- out_valid = in_valid delayed by 2 cycles.
- Pipeline registers load only when their stage valid bit is set. Z holds its last value otherwise.

Reset
- rst_n low asynchronously clears Z to 0, out_valid to 0, and all stage valids/registers to 0.
- Reset mid-operation discards in-flight results.
- The first out_valid after release comes 2 cycles after the first accepted in_valid.

Test Plan:
- 1.5 × 1.5: X = Y = 0x40400000 → 0x40900000 (2.25, normalise path); out_valid exactly 2 cycles after in_valid. 1.0 × 1.0 (0x40000000 each) → 0x40000001 (ILSB rounding up).
- 1.25 × 4.0: 0x40200000 × 0x41000000 → 0x41200001. −1.5 × 1.5: 0xC0400000 × 0x40400000 → 0xC0900000.
- Specials:
  - 0x7FFFFFFF × 0x40C00000 → 0x7FFFFFFF.
  - 0xFFFFFFFF × 0xC0A00000 → 0x7FFFFFFF.
  - 0x00000000 × 0x40A00000 → 0x00000000.
  - 0xFFFFFFFF × 0x00000000 → 0x80000000 (zero beats inf).
- Range: 0x7F000000 × 0x7F000000 → 0x7FFFFFFF (overflow). 0x00800000 × 0x00800000 → 0x00000000 (underflow).
- Streaming: back-to-back in_valid for 4 vectors → 4 consecutive out_valid cycles in order. Deassert rst_n mid-stream → Z = 0 and out_valid = 0 immediately; no stale results after release.
- Random normal operands vs. reference model (exact product of the HUB values, truncated as specified) over ≥10k vectors; bit-exact match.
